// File: rtl/tick_sched_pkg.sv
// tick_sched_pkg -- shared types and constants for the tick scheduler.
//
// Contents:
//   NCH_DEF, CNT_W_DEF, PRE_DIV_DEF : default parameter values
//   CH_W_MAX, DIV_W_MAX             : field widths of the pending-request
//                                     slot; sized for up to 16 channels and
//                                     divisors up to 32 bits
//   DIV_STOP                        : divisor value that means "stop"
//   tick_cfg_t                      : pending configuration request {ch, div, en}
//   clog2_min1()                    : channel-select width, never below 1
package tick_sched_pkg;

  localparam int NCH_DEF     = 4;
  localparam int CNT_W_DEF   = 26;
  localparam int PRE_DIV_DEF = 1;

  localparam int CH_W_MAX  = 4;
  localparam int DIV_W_MAX = 32;

  localparam logic [DIV_W_MAX-1:0] DIV_STOP = '0;

  typedef struct packed {
    logic [CH_W_MAX-1:0]  ch;
    logic [DIV_W_MAX-1:0] div;
    logic                 en;
  } tick_cfg_t;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tick_chan.sv
// tick_chan -- one divide-by-N tick channel.
//
// Holds the channel's divisor, up-counter and run flag. While running, the
// counter advances on each shared prescaler tick; the cycle where it reaches
// div-1 on a prescaler tick is the boundary, and the tick pulse is registered
// from it.
//
// Optional feature (macro TICK_SCHED_TOGGLE_EN): adds a square-wave output
// that toggles whenever the tick register is set. It holds its value while
// the channel is stopped.
//
// Ports:
//   clk, reset  : clock, asynchronous active-low reset
//   pre_tick    : shared prescaler enable
//   load        : start / reload with load_div, counter cleared
//   stop        : stop the channel, counter cleared
//   load_div    : divisor used by load
//   boundary    : combinational boundary flag (used for reload sequencing)
//   tick        : registered one-cycle tick
//   active      : channel running
//   sq          : square wave (TICK_SCHED_TOGGLE_EN only)
module tick_chan #(
  parameter int CNT_W = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pre_tick,
  input  logic             load,
  input  logic             stop,
  input  logic [CNT_W-1:0] load_div,
  output logic             boundary,
  output logic             tick,
  output logic             active
`ifdef TICK_SCHED_TOGGLE_EN
  , output logic           sq
`endif
);

  logic [CNT_W-1:0] div;
  logic [CNT_W-1:0] cnt;
  logic             en;

  // div is never 0 while en is set, so div-1 cannot wrap here.
  assign boundary = en && pre_tick && (cnt == div - CNT_W'(1));
  assign active   = en;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div  <= '0;
      cnt  <= '0;
      en   <= 1'b0;
      tick <= 1'b0;
    end else begin
      // A boundary tick is registered even when a stop lands in the same cycle.
      tick <= boundary;
      if (stop) begin
        en  <= 1'b0;
        cnt <= '0;
      end else if (load) begin
        en  <= 1'b1;
        div <= load_div;
        cnt <= '0;
      end else if (boundary) begin
        cnt <= '0;
      end else if (en && pre_tick) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

`ifdef TICK_SCHED_TOGGLE_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sq <= 1'b0;
    end else if (boundary) begin
      sq <= ~sq;
    end
  end
`endif

endmodule

// File: rtl/tick_scheduler.sv
// tick_scheduler -- multi-channel clock-enable scheduler.
//
// One shared prescaler (period PRE_DIV clk) feeds NCH independent
// divide-by-div channels that emit single-cycle tick_o enables. Channels are
// (re)configured through a valid/ready port backed by a single pending slot:
// starts and stops apply on the cycle after acceptance, while a new divisor
// for a running channel waits for that channel's tick boundary so no short
// or long period is ever produced. Out-of-range channel numbers are accepted
// and dropped.
//
// Optional feature (macro TICK_SCHED_TOGGLE_EN): sq_o square-wave outputs.
//
// Ports:
//   clk, reset  : clock, asynchronous active-low reset
//   cfg_valid   : request valid         cfg_ready : slot empty
//   cfg_ch      : target channel        cfg_div   : divisor (prescaler ticks)
//   cfg_en      : 1 = run, 0 = stop (cfg_div = 0 also stops)
//   tick_o      : per-channel tick      active_o  : per-channel running
//   sq_o        : per-channel square wave (TICK_SCHED_TOGGLE_EN only)
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter int NCH     = NCH_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int PRE_DIV = PRE_DIV_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [clog2_min1(NCH)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]           cfg_div,
  input  logic                       cfg_en,
  output logic [NCH-1:0]             tick_o,
  output logic [NCH-1:0]             active_o
`ifdef TICK_SCHED_TOGGLE_EN
  , output logic [NCH-1:0]           sq_o
`endif
);

  localparam int PRE_W = (PRE_DIV <= 2) ? 1 : $clog2(PRE_DIV);

  // Shared prescaler
  logic [PRE_W-1:0] pre_cnt;
  logic             pre_tick;

  assign pre_tick = (pre_cnt == PRE_W'(PRE_DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_cnt <= '0;
    end else if (pre_tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  // Pending request slot
  tick_cfg_t pend;
  logic      pend_valid;
  logic      pend_in_range;
  logic      pend_stop;
  logic      apply_done;

  logic [NCH-1:0] boundary;
  logic [NCH-1:0] load;
  logic [NCH-1:0] stop;

  assign cfg_ready     = !pend_valid;
  assign pend_in_range = (32'(pend.ch) < 32'(NCH));
  assign pend_stop     = !pend.en || (pend.div == DIV_STOP);

  // Out-of-range and stop requests retire at once; a start retires when its
  // channel loads (immediately if stopped, at the boundary if running).
  assign apply_done = pend_valid && (!pend_in_range || pend_stop || (|load));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_valid <= 1'b0;
      pend       <= '0;
    end else if (cfg_valid && cfg_ready) begin
      pend_valid <= 1'b1;
      pend       <= '{ch: CH_W_MAX'(cfg_ch), div: DIV_W_MAX'(cfg_div), en: cfg_en};
    end else if (apply_done) begin
      pend_valid <= 1'b0;
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    logic hit;

    assign hit      = pend_valid && pend_in_range && (pend.ch == CH_W_MAX'(gi));
    assign stop[gi] = hit && pend_stop;
    assign load[gi] = hit && !pend_stop && (!active_o[gi] || boundary[gi]);

    tick_chan #(
      .CNT_W (CNT_W)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .pre_tick (pre_tick),
      .load     (load[gi]),
      .stop     (stop[gi]),
      .load_div (pend.div[CNT_W-1:0]),
      .boundary (boundary[gi]),
      .tick     (tick_o[gi]),
      .active   (active_o[gi])
`ifdef TICK_SCHED_TOGGLE_EN
      , .sq     (sq_o[gi])
`endif
    );
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// tb_tick_scheduler -- scoreboard bench for tick_scheduler.
//
// Two instances run side by side: A (NCH=4, CNT_W=26, PRE_DIV=1) and
// B (NCH=3, CNT_W=8, PRE_DIV=4, so cfg_ch=3 is out of range). Each cycle the
// stimulus process advances a reference model (per channel: running flag,
// divisor and number of prescaler ticks remaining until the next tick) and
// pushes the expected outputs into a queue; a monitor on the falling edge
// pops and compares. Directed starts open the run, then random requests,
// with one reset asserted while a request is pending.
module tb_tick_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        va, vb, ena, enb, ra, rb;
  logic [1:0]  cha, chb;
  logic [25:0] diva;
  logic [7:0]  divb;
  logic [3:0]  ticka, acta;
  logic [2:0]  tickb, actb;
`ifdef TICK_SCHED_TOGGLE_EN
  logic [3:0]  sqa;
  logic [2:0]  sqb;
`endif

  tick_scheduler #(.NCH(4), .CNT_W(26), .PRE_DIV(1)) dut_a (
    .clk(clk), .reset(reset), .cfg_valid(va), .cfg_ready(ra), .cfg_ch(cha),
    .cfg_div(diva), .cfg_en(ena), .tick_o(ticka), .active_o(acta)
`ifdef TICK_SCHED_TOGGLE_EN
    , .sq_o(sqa)
`endif
  );

  tick_scheduler #(.NCH(3), .CNT_W(8), .PRE_DIV(4)) dut_b (
    .clk(clk), .reset(reset), .cfg_valid(vb), .cfg_ready(rb), .cfg_ch(chb),
    .cfg_div(divb), .cfg_en(enb), .tick_o(tickb), .active_o(actb)
`ifdef TICK_SCHED_TOGGLE_EN
    , .sq_o(sqb)
`endif
  );

  typedef struct {
    bit [3:0] tick;
    bit [3:0] act;
    bit [3:0] sq;
    bit       rdy;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  int checks = 0;
  int errors = 0;

  // Reference model state, index [instance][channel]
  int nch_k[2] = '{4, 3};
  int pre_k[2] = '{1, 4};
  bit run_m[2][4];
  int div_m[2][4];
  int rem_m[2][4];
  bit tick_m[2][4];
  bit sq_m[2][4];
  bit pv_m[2];
  bit pen_m[2];
  int pch_m[2];
  int pdiv_m[2];
  int cyc_m[2];

  // Driven request per instance
  bit v_in[2];
  bit en_in[2];
  int ch_in[2];
  int div_in[2];
  bit acc[2];

  int edge_n  = 0;
  bit mon_en  = 1'b0;
  int rst_cnt = 0;
  bit did_rst = 1'b0;
  int acc_a   = -1;
  int ta1 = -1, ta2 = -1, tb1 = -1, tb2 = -1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d got=%0h expected=%0h", name, edge_n, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) begin
        run_m[k][i] = 0; div_m[k][i] = 0; rem_m[k][i] = 0;
        tick_m[k][i] = 0; sq_m[k][i] = 0;
      end
      pv_m[k] = 0; pen_m[k] = 0; pch_m[k] = 0; pdiv_m[k] = 0; cyc_m[k] = 0;
    end
  endtask

  // One rising edge of instance k.
  task automatic model_edge(input int k);
    bit pt;
    bit rdy;
    bit bnd[4];
    int c;
    pt = ((cyc_m[k] % pre_k[k]) == pre_k[k] - 1);
    cyc_m[k]++;
    rdy = !pv_m[k];
    for (int i = 0; i < 4; i++)
      bnd[i] = (i < nch_k[k]) && run_m[k][i] && pt && (rem_m[k][i] == 1);
    for (int i = 0; i < nch_k[k]; i++) begin
      tick_m[k][i] = bnd[i];
      if (bnd[i]) sq_m[k][i] = !sq_m[k][i];
      if (run_m[k][i] && pt) rem_m[k][i] = bnd[i] ? div_m[k][i] : rem_m[k][i] - 1;
    end
    if (pv_m[k]) begin
      c = pch_m[k];
      if (c >= nch_k[k]) begin
        pv_m[k] = 0;
      end else if (!pen_m[k] || pdiv_m[k] == 0) begin
        run_m[k][c] = 0; pv_m[k] = 0;
      end else if (!run_m[k][c]) begin
        run_m[k][c] = 1; div_m[k][c] = pdiv_m[k]; rem_m[k][c] = pdiv_m[k]; pv_m[k] = 0;
      end else if (bnd[c]) begin
        div_m[k][c] = pdiv_m[k]; rem_m[k][c] = pdiv_m[k]; pv_m[k] = 0;
      end
    end
    acc[k] = v_in[k] && rdy;
    if (acc[k]) begin
      pv_m[k] = 1; pch_m[k] = ch_in[k]; pdiv_m[k] = div_in[k]; pen_m[k] = en_in[k];
    end
  endtask

  function automatic exp_t mk(input int k);
    exp_t e;
    e.tick = '0; e.act = '0; e.sq = '0;
    for (int i = 0; i < nch_k[k]; i++) begin
      e.tick[i] = tick_m[k][i];
      e.act[i]  = run_m[k][i];
      e.sq[i]   = sq_m[k][i];
    end
    e.rdy = !pv_m[k];
    return e;
  endfunction

  task automatic next_req(input int k);
    if (acc[k]) v_in[k] = 0;
    if (!v_in[k]) begin
      if (edge_n == 8) begin
        v_in[k] = 1; en_in[k] = 1;
        ch_in[k]  = (k == 0) ? 0 : 1;
        div_in[k] = (k == 0) ? 5 : 3;
      end else if (edge_n >= 80 && $urandom_range(0, 3) == 0) begin
        v_in[k]   = 1;
        ch_in[k]  = $urandom_range(0, 3);
        en_in[k]  = ($urandom_range(0, 5) != 0);
        div_in[k] = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 9);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    va = 0; vb = 0; ena = 0; enb = 0; cha = 0; chb = 0; diva = 0; divb = 0;
    for (int k = 0; k < 2; k++) begin
      v_in[k] = 0; en_in[k] = 0; ch_in[k] = 0; div_in[k] = 0; acc[k] = 0;
    end
    model_reset();
    rst_cnt = 3;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      edge_n++;
      acc[0] = 0; acc[1] = 0;
      if (reset) begin
        model_edge(0);
        model_edge(1);
      end
      #2;
      for (int k = 0; k < 2; k++)
        if (acc[k])
          $display("[%s] edge=%0d accept ch=%0d div=%0d en=%0d",
                   (k == 0) ? "A" : "B", edge_n, ch_in[k], div_in[k], en_in[k]);
      if (acc[0] && acc_a < 0) acc_a = edge_n;
      if (rst_cnt > 0) begin
        rst_cnt--;
        if (rst_cnt == 0) reset = 1'b1;
      end else if (!did_rst && edge_n >= 1500 && pv_m[0]) begin
        reset = 1'b0; did_rst = 1; rst_cnt = 3;
        model_reset();
        $display("[A/B] edge=%0d reset asserted with request pending", edge_n);
      end
      if (reset && rst_cnt == 0) begin
        next_req(0);
        next_req(1);
      end else begin
        v_in[0] = 0; v_in[1] = 0;
      end
      va = v_in[0]; cha = 2'(ch_in[0]); diva = 26'(div_in[0]); ena = en_in[0];
      vb = v_in[1]; chb = 2'(ch_in[1]); divb = 8'(div_in[1]);  enb = en_in[1];
      qa.push_back(mk(0));
      qb.push_back(mk(1));
      mon_en = 1'b1;
    end
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    chk("A.first_tick_latency", 32'(ta1 - acc_a), 32'd6);
    chk("A.period_div5", 32'(ta2 - ta1), 32'd5);
    chk("B.period_div3_pre4", 32'(tb2 - tb1), 32'd12);
    chk("A.queue_drained", 32'(qa.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (edge_n < 80) begin
        if (ticka[0] === 1'b1) begin
          if (ta1 < 0) ta1 = edge_n; else if (ta2 < 0) ta2 = edge_n;
        end
        if (tickb[1] === 1'b1) begin
          if (tb1 < 0) tb1 = edge_n; else if (tb2 < 0) tb2 = edge_n;
        end
      end
      if (qa.size() == 0 || qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty edge=%0d got=%0d/%0d entries expected>=1",
                 edge_n, qa.size(), qb.size());
      end else begin
        e = qa.pop_front();
        chk("A.tick_o",    32'(ticka), 32'(e.tick));
        chk("A.active_o",  32'(acta),  32'(e.act));
        chk("A.cfg_ready", 32'(ra),    32'(e.rdy));
`ifdef TICK_SCHED_TOGGLE_EN
        chk("A.sq_o",      32'(sqa),   32'(e.sq));
`endif
        e = qb.pop_front();
        chk("B.tick_o",    32'(tickb), 32'(e.tick[2:0]));
        chk("B.active_o",  32'(actb),  32'(e.act[2:0]));
        chk("B.cfg_ready", 32'(rb),    32'(e.rdy));
`ifdef TICK_SCHED_TOGGLE_EN
        chk("B.sq_o",      32'(sqb),   32'(e.sq[2:0]));
`endif
      end
    end
  end

endmodule
